// File: rtl/dp_sram.sv
// Dual-port synchronous SRAM: port A read/write with byte enables, port B read-only.
// Reads return after 1 or 2 cycles with a valid strobe and an out-of-range flag.
module dp_sram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_cs,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  output logic                    a_oob,
  input  logic                    b_cs,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  output logic                    b_oob
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  // Parameter legality is checked at elaboration.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
    $error("dp_sram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
    $error("dp_sram: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE > 1) begin : g_bad_rdw_mode
    $error("dp_sram: RDW_MODE must be 0 or 1");
  end
  if (DEPTH == 0 || 64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $error("dp_sram: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_wr;
  logic                  a_rd;
  logic                  a_in_rng;
  logic                  b_in_rng;
  logic                  mem_we;
  logic [IDX_W-1:0]      a_idx;
  logic [IDX_W-1:0]      b_idx;
  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] b_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] a_rd_word;
  logic [DATA_WIDTH-1:0] b_rd_word;

  // Request decode, range check and read-during-write merge, all in the request cycle.
  always_comb begin
    a_wr      = a_cs & a_we;
    a_rd      = a_cs & ~a_we;
    a_in_rng  = {1'b0, a_addr} < DEPTH_LIM;
    b_in_rng  = {1'b0, b_addr} < DEPTH_LIM;
    a_idx     = IDX_W'(a_addr);
    b_idx     = IDX_W'(b_addr);
    a_old     = a_in_rng ? mem[a_idx] : '0;
    b_old     = b_in_rng ? mem[b_idx] : '0;
    wr_merged = a_old;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (a_be[i]) begin
        wr_merged[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
    // rst_n gate keeps requests seen during reset from touching the array.
    mem_we    = a_wr & a_in_rng & rst_n;
    a_rd_word = a_old;
    b_rd_word = b_old;
    if (RDW_MODE == 1 && a_wr && a_in_rng && b_in_rng && (a_addr == b_addr)) begin
      b_rd_word = wr_merged;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[a_idx] <= wr_merged;
    end
  end

  logic                  a_tail_v;
  logic                  a_tail_o;
  logic [DATA_WIDTH-1:0] a_tail_d;
  logic                  b_tail_v;
  logic                  b_tail_o;
  logic [DATA_WIDTH-1:0] b_tail_d;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  a_s1_v;
    logic                  a_s1_o;
    logic [DATA_WIDTH-1:0] a_s1_d;
    logic                  b_s1_v;
    logic                  b_s1_o;
    logic [DATA_WIDTH-1:0] b_s1_d;

    // Extra pipeline stage in front of the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_s1_v <= 1'b0;
        a_s1_o <= 1'b0;
        a_s1_d <= '0;
        b_s1_v <= 1'b0;
        b_s1_o <= 1'b0;
        b_s1_d <= '0;
      end else begin
        a_s1_v <= a_rd;
        a_s1_o <= a_rd & ~a_in_rng;
        b_s1_v <= b_cs;
        b_s1_o <= b_cs & ~b_in_rng;
        if (a_rd) begin
          a_s1_d <= a_rd_word;
        end
        if (b_cs) begin
          b_s1_d <= b_rd_word;
        end
      end
    end

    always_comb begin
      a_tail_v = a_s1_v;
      a_tail_o = a_s1_o;
      a_tail_d = a_s1_d;
      b_tail_v = b_s1_v;
      b_tail_o = b_s1_o;
      b_tail_d = b_s1_d;
    end
  end else begin : g_lat1
    always_comb begin
      a_tail_v = a_rd;
      a_tail_o = a_rd & ~a_in_rng;
      a_tail_d = a_rd_word;
      b_tail_v = b_cs;
      b_tail_o = b_cs & ~b_in_rng;
      b_tail_d = b_rd_word;
    end
  end

  // Output stage: data loads only on a strobe so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_oob    <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_oob    <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_tail_v;
      a_oob    <= (a_tail_v & a_tail_o) | (a_wr & ~a_in_rng);
      b_rvalid <= b_tail_v;
      b_oob    <= b_tail_v & b_tail_o;
      if (a_tail_v) begin
        a_rdata <= a_tail_d;
      end
      if (b_tail_v) begin
        b_rdata <= b_tail_d;
      end
    end
  end

endmodule

// File: tb/tb_dp_sram.sv
// Directed bench for dp_sram: two instances (latency 1 / old-data RDW and
// latency 2 / merged RDW), both with DEPTH=1000, share one stimulus stream.
module tb_dp_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_cs;
  logic        a_we;
  logic [3:0]  a_be;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_cs;
  logic [9:0]  b_addr;

  logic [31:0] m0_a_rdata, m0_b_rdata, m1_a_rdata, m1_b_rdata;
  logic        m0_a_rvalid, m0_a_oob, m0_b_rvalid, m0_b_oob;
  logic        m1_a_rvalid, m1_a_oob, m1_b_rvalid, m1_b_oob;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dp_sram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1000), .RD_LATENCY(1), .RDW_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(m0_a_rdata), .a_rvalid(m0_a_rvalid), .a_oob(m0_a_oob),
    .b_cs(b_cs), .b_addr(b_addr),
    .b_rdata(m0_b_rdata), .b_rvalid(m0_b_rvalid), .b_oob(m0_b_oob)
  );

  dp_sram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1000), .RD_LATENCY(2), .RDW_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(m1_a_rdata), .a_rvalid(m1_a_rvalid), .a_oob(m1_a_oob),
    .b_cs(b_cs), .b_addr(b_addr),
    .b_rdata(m1_b_rdata), .b_rvalid(m1_b_rvalid), .b_oob(m1_b_oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_cs = 1'b0;
    a_we = 1'b0;
    b_cs = 1'b0;
  endtask

  // Write one word, then check the write-side oob pulse on both instances.
  task automatic wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input logic exp_oob);
    a_cs = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
    tick();
    idle();
    chk("wr_oob", 32'({m0_a_oob, m1_a_oob, m0_a_rvalid, m1_a_rvalid}),
        32'({exp_oob, exp_oob, 2'b00}));
  endtask

  // Read on both ports at once; m0 answers after one edge, m1 after two.
  task automatic rd_both(input logic [9:0] aa, input logic [31:0] ea,
                         input logic [9:0] ba, input logic [31:0] eb,
                         input logic oa, input logic ob);
    a_cs = 1'b1; a_we = 1'b0; a_addr = aa; b_cs = 1'b1; b_addr = ba;
    tick();
    idle();
    chk("rd_m0_a_data", m0_a_rdata, ea);
    chk("rd_m0_b_data", m0_b_rdata, eb);
    chk("rd_m0_flags", 32'({m0_a_rvalid, m0_a_oob, m0_b_rvalid, m0_b_oob}),
        32'({1'b1, oa, 1'b1, ob}));
    chk("rd_m1_early", 32'({m1_a_rvalid, m1_b_rvalid}), 32'd0);
    tick();
    chk("rd_m1_a_data", m1_a_rdata, ea);
    chk("rd_m1_b_data", m1_b_rdata, eb);
    chk("rd_m1_flags", 32'({m1_a_rvalid, m1_a_oob, m1_b_rvalid, m1_b_oob}),
        32'({1'b1, oa, 1'b1, ob}));
    chk("rd_m0_strobe_end", 32'({m0_a_rvalid, m0_b_rvalid}), 32'd0);
    chk("rd_m0_hold", m0_a_rdata ^ m0_b_rdata, ea ^ eb);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'({m0_a_rvalid, m0_b_rvalid, m0_a_oob, m0_b_oob,
                  m1_a_rvalid, m1_b_rvalid, m1_a_oob, m1_b_oob}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_be = 4'h0; a_addr = '0; a_wdata = '0; b_addr = '0;
    idle();

    // Reset with random requests: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      a_cs = 1'($urandom); a_we = 1'($urandom); a_be = 4'($urandom);
      a_addr = 10'($urandom); a_wdata = $urandom; b_cs = 1'($urandom); b_addr = 10'($urandom);
      tick();
      chk_quiet("rst_flags");
      chk("rst_data", m0_a_rdata | m0_b_rdata | m1_a_rdata | m1_b_rdata, 32'd0);
    end
    idle();
    rst_n = 1'b1;
    tick();
    chk_quiet("post_rst_idle");

    // Basic write then read on both ports.
    wr(10'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    rd_both(10'd5, 32'hDEADBEEF, 10'd5, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte enables, including an all-zero enable write.
    wr(10'd7, 32'h11223344, 4'hF, 1'b0);
    wr(10'd7, 32'hAABBCCDD, 4'h5, 1'b0);
    rd_both(10'd7, 32'h11BB33DD, 10'd7, 32'h11BB33DD, 1'b0, 1'b0);
    wr(10'd7, 32'h00000000, 4'h0, 1'b0);
    rd_both(10'd7, 32'h11BB33DD, 10'd5, 32'hDEADBEEF, 1'b0, 1'b0);

    // Cross-port collision on addr 9.
    wr(10'd9, 32'h00000000, 4'hF, 1'b0);
    a_cs = 1'b1; a_we = 1'b1; a_addr = 10'd9; a_wdata = 32'hFFFF0000; a_be = 4'hC;
    b_cs = 1'b1; b_addr = 10'd9;
    tick();
    idle();
    chk("rdw1_m0_b", m0_b_rdata, 32'h00000000);
    chk("rdw1_m0_flags", 32'({m0_b_rvalid, m0_b_oob, m0_a_rvalid}), 32'b100);
    tick();
    chk("rdw1_m1_b", m1_b_rdata, 32'hFFFF0000);
    chk("rdw1_m1_flags", 32'({m1_b_rvalid, m1_b_oob, m1_a_rvalid}), 32'b100);
    rd_both(10'd9, 32'hFFFF0000, 10'd9, 32'hFFFF0000, 1'b0, 1'b0);

    // Second collision with a non-zero old word: merge must keep unenabled bytes.
    a_cs = 1'b1; a_we = 1'b1; a_addr = 10'd9; a_wdata = 32'h0000ABCD; a_be = 4'h1;
    b_cs = 1'b1; b_addr = 10'd9;
    tick();
    idle();
    chk("rdw2_m0_b", m0_b_rdata, 32'hFFFF0000);
    tick();
    chk("rdw2_m1_b", m1_b_rdata, 32'hFFFF00CD);
    rd_both(10'd9, 32'hFFFF00CD, 10'd9, 32'hFFFF00CD, 1'b0, 1'b0);

    // Streaming: A reads 0..15, B reads 15..0 back to back.
    for (int i = 0; i < 16; i++) wr(10'(i), 32'(i), 4'hF, 1'b0);
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        a_cs = 1'b1; a_we = 1'b0; a_addr = 10'(k); b_cs = 1'b1; b_addr = 10'(15 - k);
      end else begin
        idle();
      end
      tick();
      chk("st_m0_valid", 32'({m0_a_rvalid, m0_b_rvalid}), (k < 16) ? 32'd3 : 32'd0);
      chk("st_m0_a", m0_a_rdata, (k < 16) ? 32'(k) : 32'd15);
      chk("st_m0_b", m0_b_rdata, (k < 16) ? 32'(15 - k) : 32'd0);
      chk("st_m1_valid", 32'({m1_a_rvalid, m1_b_rvalid}), (k >= 1 && k <= 16) ? 32'd3 : 32'd0);
      if (k >= 1 && k <= 16) begin
        chk("st_m1_a", m1_a_rdata, 32'(k - 1));
        chk("st_m1_b", m1_b_rdata, 32'(16 - k));
      end
    end

    // Out of range: last valid word, dropped write, oob reads.
    wr(10'd999, 32'hCAFEF00D, 4'hF, 1'b0);
    wr(10'd1000, 32'h55AA55AA, 4'hF, 1'b1);
    tick();
    chk_quiet("wr_oob_pulse_end");
    rd_both(10'd999, 32'hCAFEF00D, 10'd1023, 32'h00000000, 1'b0, 1'b1);
    rd_both(10'd1000, 32'h00000000, 10'd999, 32'hCAFEF00D, 1'b1, 1'b0);
    rd_both(10'd0, 32'h00000000, 10'd8, 32'h00000008, 1'b0, 1'b0);

    // Reset while the latency-2 read is in flight.
    a_cs = 1'b1; a_we = 1'b0; a_addr = 10'd3; b_cs = 1'b1; b_addr = 10'd12;
    tick();
    idle();
    chk("mr_m0_a", m0_a_rdata, 32'd3);
    rst_n = 1'b0;
    #1;
    chk_quiet("mr_async_clear");
    chk("mr_data_clear", m0_a_rdata | m0_b_rdata | m1_a_rdata | m1_b_rdata, 32'd0);
    tick();
    chk_quiet("mr_in_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("mr_no_strobe");
    end
    rd_both(10'd3, 32'd3, 10'd12, 32'd12, 1'b0, 1'b0);
    rd_both(10'd999, 32'hCAFEF00D, 10'd7, 32'h00000007, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
